// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types, ASCII constants and hex formatting for the result UART
package cnn_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} uart_tx_state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - one 8N1 frame per start pulse; owns baud and bit counters
module uart_tx_byte
   import cnn_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int BW = $clog2(CLKS_PER_BIT);

   uart_tx_state_t state, state_nxt;
   logic [BW-1:0]  baud_cnt;
   logic [2:0]     bit_cnt;
   logic [7:0]     shift;
   logic           baud_last;

   assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (start)
               shift <= data;
         end else begin
            baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
            // bit_cnt wraps back to 0 after bit 7, ready for the next frame
            if (state == DATA && baud_last) begin
               shift   <= {1'b0, shift[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = START;
         START:   if (baud_last) state_nxt = DATA;
         DATA:    if (baud_last && bit_cnt == 3'd7) state_nxt = STOP;
         STOP:    if (baud_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx   = 1'b1;
      done = 1'b0;
      case (state)
         START:   tx = 1'b0;
         DATA:    tx = shift[0];
         STOP:    done = baud_last;
         default: tx = 1'b1;
      endcase
   end

endmodule

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - reports the argmax class as a hex ASCII char over UART; RESULT_UART_CRLF_EN appends CR LF
module result_uart_tx
   import cnn_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD        = 115200,
   parameter int IDXW        = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            res_valid,
   input  logic [IDXW-1:0] res_idx,
   output logic            tx,
   output logic            busy,
   output logic            overrun
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("result_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
      end
   endgenerate

   // Top-level START covers the whole frame; the byte engine sequences START/DATA/STOP.
   uart_tx_state_t state, state_nxt;
   logic           byte_start;
   logic [7:0]     byte_data;
   logic           byte_done;
   logic           more;
   logic [7:0]     next_byte;

`ifdef RESULT_UART_CRLF_EN
   logic [1:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         byte_cnt <= '0;
      else if (state == IDLE && res_valid)
         byte_cnt <= '0;
      else if (state == NEXT && more)
         byte_cnt <= byte_cnt + 2'd1;
   end

   assign more      = (byte_cnt != 2'd2);
   assign next_byte = (byte_cnt == 2'd0) ? ASCII_CR : ASCII_LF;
`else
   assign more      = 1'b0;
   assign next_byte = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (res_valid) state_nxt = START;
         START:   if (byte_done) state_nxt = NEXT;
         NEXT:    state_nxt = more ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      byte_start = 1'b0;
      byte_data  = hex_to_ascii(res_idx[3:0]);
      busy       = (state != IDLE);
      case (state)
         IDLE: byte_start = res_valid;
         NEXT: begin
            byte_start = more;
            byte_data  = next_byte;
         end
         default: byte_start = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         overrun <= 1'b0;
      else
         overrun <= res_valid && (state != IDLE);
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk   (clk),
      .reset (reset),
      .start (byte_start),
      .data  (byte_data),
      .tx    (tx),
      .done  (byte_done)
   );

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Result reporter for the classifier. It captures the winning class index when the argmax stage pulses `done`, formats it as an ASCII hex character, and serialises it on a UART 8N1 line to the host. It sits at the output of the inference pipeline, on the consuming end of the argmax start/done handshake. It is the only block that drives the board's UART TX pin.

## Interface
- `CLK_FREQ_HZ`, 100_000_000, system clock frequency.
- `BAUD`, 115200, line rate.
- `IDXW`, 4, width of the incoming class index.
- `CLKS_PER_BIT`, CLK_FREQ_HZ/BAUD (integer divide), derived. Must be ≥ 2 (elaboration error otherwise).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `res_valid`  in  1  one-cycle pulse; argmax `done`.
- `res_idx`  in  IDXW  class index; valid when `res_valid`=1.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high while a message is in flight.
- `overrun`  out  1  one-cycle pulse when a result is dropped.

## Operation
- Message: one ASCII character per result.
  - Index values 0–9 map to 0x30–0x39.
  - Index values 10–15 map to 0x41–0x46 ('A'–'F').
  - Only the low 4 bits of `res_idx` are used. Upper bits, if `IDXW` > 4, are ignored.
  - Optional CR (0x0D) and LF (0x0A) are appended; see Configuration.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- FSM states: IDLE, START, DATA, STOP, NEXT.
  - IDLE: `tx`=1. On `res_valid`=1, latch the character and set the byte counter to 0. Go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with the bit counter at 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to NEXT.
  - NEXT: lasts one cycle with `tx`=1. If more bytes remain, load the next byte and go to START; otherwise go to IDLE.
- Counters:
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - The bit counter is 3 bits.
  - The byte counter is 2 bits.
- `busy`=1 in every state except IDLE.
- A `res_valid` that arrives while not in IDLE drops that result and pulses `overrun` on the next cycle. The message in flight is unaffected.
- A `res_valid` in IDLE is accepted. It never causes `overrun`.

## Timing
- Reset values: `tx`=1, `busy`=0, `overrun`=0. State is IDLE and all counters are 0.
- Reset mid-frame takes effect on the next clock edge: `tx` returns high immediately and the partial frame is abandoned.
- Capture latency: `res_valid` sampled high at edge N gives `tx`=0 and `busy`=1 from edge N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Single-byte message: `busy` is high for 10·CLKS_PER_BIT + 1 cycles.
- Three-byte message: `busy` is high for 30·CLKS_PER_BIT + 3 cycles. Between bytes the line idles for exactly one NEXT cycle after the stop bit.
- A result can be accepted again on the first cycle after `busy` falls. There are no back-to-back acceptance restrictions beyond that.

## Configuration
- `RESULT_UART_CRLF_EN` defined: each message is 3 bytes: character, 0x0D, 0x0A.
- Not defined: each message is the single character, and the byte counter logic is removed.

## Structure
- Shared package `cnn_pkg`:
  - the state enum `uart_tx_state_t`;
  - the ASCII constants `ASCII_CR` and `ASCII_LF`;
  - the function `hex_to_ascii(logic [3:0])`.
- Sub-module `uart_tx_byte`:
  - Inputs: `clk`, `reset`, `start`, `data[7:0]`.
  - Outputs: `tx`, `done`.
  - Owns the baud and bit counters and the START/DATA/STOP sequencing.
- Top level (`result_uart_tx`) owns capture, formatting, the byte counter, the NEXT logic and overrun detection.

## Test plan
All scenarios run with CLK_FREQ_HZ=1000 and BAUD=250, so CLKS_PER_BIT=4.
- Reset: hold `reset` 3 cycles, then release → `tx`=1, `busy`=0, `overrun`=0. No activity for 100 cycles.
- Single-byte message (CRLF off): `res_idx`=7 pulse → line decodes 0x37, LSB first. `tx` low exactly 4 cycles for the start bit. `busy` high 41 cycles.
- Hex mapping: `res_idx`=0, 9, 10, 15 in sequence, each waiting for `busy` to fall → bytes 0x30, 0x39, 0x41, 0x46.
- CRLF message (CRLF on): `res_idx`=3 → bytes 0x33, 0x0D, 0x0A. One idle-high cycle between frames. `busy` high 123 cycles.
- Overrun: `res_idx`=2, then `res_idx`=5 pulsed 20 cycles later → `overrun` pulses once on the cycle after the second pulse. Only 0x32 is transmitted.
- Reset mid-frame: assert `reset` during data bit 3 → `tx`=1 and `busy`=0 next cycle. A following `res_idx`=4 transmits a clean 0x34.
